// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: datapath widths, writeback result select
// encoding and the load funct3 codes understood by the load extender.
package rv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned NUM_REGS  = 32;

   // Writeback result select; 2'b11 is reserved and yields zero.
   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   // Load funct3 encodings.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage : rv_pkg

// File: rtl/load_extend.sv
// Load data aligner / extender, purely combinational. Shared with the
// single-cycle core.
//   funct3_i  load type (LB/LH/LW/LBU/LHU; anything else passes the word)
//   addr_i    low two bits of the byte address
//   word_i    raw aligned memory word
//   ext_o     aligned and sign/zero-extended load value
module load_extend
   import rv_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_i,
   input  logic [XLEN-1:0] word_i,
   output logic [XLEN-1:0] ext_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection; halfword lane ignores addr bit 0.
   always_comb begin
      byte_sel = word_i[7:0];
      case (addr_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
   end

   // Extension by load type.
   always_comb begin
      ext_o = word_i;
      case (funct3_i)
         F3_LB:   ext_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  ext_o = {24'h0, byte_sel};
         F3_LH:   ext_o = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  ext_o = {16'h0, half_sel};
         F3_LW:   ext_o = word_i;
         default: ext_o = word_i;
      endcase
   end

endmodule : load_extend

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the writeback result, extends load data and
// commits into the x1..x31 register file. Serves the decode stage's two
// asynchronous read ports with same-cycle write-to-read bypass.
//   i_Clk, i_Reset              clock, async active-low reset (clears regs)
//   i_RegWriteW                 commit enable
//   i_ResultSrcW                00 ALU, 01 load, 10 PC+4, 11 zero
//   i_Funct3W                   load type
//   i_ALUResultW                ALU result / load byte address
//   i_ReadDataW                 raw memory word
//   i_RdW                       destination register
//   i_PCPlus4W                  link value
//   i_Rs1D, i_Rs2D              decode read indices
//   o_ResultW                   writeback value (combinational)
//   o_RD1D, o_RD2D              decode read data (combinational)
module writeback_regfile
   import rv_pkg::*;
(
   input  logic                 i_Clk,
   input  logic                 i_Reset,
   input  logic                 i_RegWriteW,
   input  logic [1:0]           i_ResultSrcW,
   input  logic [2:0]           i_Funct3W,
   input  logic [XLEN-1:0]      i_ALUResultW,
   input  logic [XLEN-1:0]      i_ReadDataW,
   input  logic [REG_IDX_W-1:0] i_RdW,
   input  logic [XLEN-1:0]      i_PCPlus4W,
   input  logic [REG_IDX_W-1:0] i_Rs1D,
   input  logic [REG_IDX_W-1:0] i_Rs2D,
   output logic [XLEN-1:0]      o_ResultW,
   output logic [XLEN-1:0]      o_RD1D,
   output logic [XLEN-1:0]      o_RD2D
);

   logic [XLEN-1:0] regs_q [1:NUM_REGS-1];
   logic [XLEN-1:0] load_ext;
   logic            wr_en;

   load_extend u_load_extend (
      .funct3_i (i_Funct3W),
      .addr_i   (i_ALUResultW[1:0]),
      .word_i   (i_ReadDataW),
      .ext_o    (load_ext)
   );

   // Result select; reserved encoding forces zero.
   always_comb begin
      o_ResultW = '0;
      case (i_ResultSrcW)
         RES_ALU:  o_ResultW = i_ALUResultW;
         RES_LOAD: o_ResultW = load_ext;
         RES_PC4:  o_ResultW = i_PCPlus4W;
         default:  o_ResultW = '0;
      endcase
   end

   // x0 is not stored, so writes to it never commit or bypass.
   assign wr_en = i_RegWriteW && (i_RdW != '0);

   // Register array: flops, async clear, single write port.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_en && (i_RdW == REG_IDX_W'(i))) begin
               regs_q[i] <= o_ResultW;
            end
         end
      end
   end

   // Read port 1: x0, then bypass, then array.
   always_comb begin
      o_RD1D = '0;
      if (i_Rs1D == '0) begin
         o_RD1D = '0;
      end else if (wr_en && (i_RdW == i_Rs1D)) begin
         o_RD1D = o_ResultW;
      end else begin
         o_RD1D = regs_q[i_Rs1D];
      end
   end

   // Read port 2: identical priority, independent bypass.
   always_comb begin
      o_RD2D = '0;
      if (i_Rs2D == '0) begin
         o_RD2D = '0;
      end else if (wr_en && (i_RdW == i_Rs2D)) begin
         o_RD2D = o_ResultW;
      end else begin
         o_RD2D = regs_q[i_Rs2D];
      end
   end

endmodule : writeback_regfile
